psimd_issue_queue: RTL

- Instruction issue buffer directly upstream of the PSIMD top level.
- Accepts custom-SIMD instructions plus their scalar rs1 operand from the scalar core through a valid/ready handshake, and buffers them in a small FIFO.
- Presents one instruction per slot on the PSIMD instr/rs1_core inputs.
- Holds load/store instructions stable for the full memory access window. Drives a NOP when idle.

---
 rtl/psimd_issue_queue.sv | 137 +++++++++++++
 1 files changed

// File: rtl/psimd_issue_queue.sv
// psimd_issue_queue: issue buffer between the scalar core and the PSIMD top level.
// Buffers SIMD instructions with their rs1 operand in a small FIFO and issues one
// per slot; load/store ops are held on the outputs for MEM_HOLD_CYCLES cycles.
// An empty slot drives NOP_INSTR with issue_valid low.
// Optional macro PSIMD_ISSUE_STATS_EN adds the stat_issued / stat_stall counters.
module psimd_issue_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MEM_HOLD_CYCLES = 2,
  parameter logic [31:0] NOP_INSTR       = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     core_valid,
  output logic                     core_ready,
  input  logic [31:0]              core_instr,
  input  logic [31:0]              core_rs1,
  input  logic                     flush,
  output logic [31:0]              issue_instr,
  output logic [31:0]              issue_rs1,
  output logic                     issue_valid,
  output logic                     issue_is_mem,
  output logic [$clog2(DEPTH):0]   count
`ifdef PSIMD_ISSUE_STATS_EN
  ,
  output logic [31:0]              stat_issued,
  output logic [31:0]              stat_stall
`endif
);

  localparam int         AW        = $clog2(DEPTH);
  localparam int         CW        = AW + 1;
  localparam bit         HOLD_EN   = (MEM_HOLD_CYCLES > 1);
  localparam logic [3:0] HOLD_INIT = 4'(MEM_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MEM_HOLD} state_t;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   rs1_mem   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  state_t        state;
  logic [3:0]    hold_cnt;

  logic          push;
  logic          pop;
  logic          slot_free;
  logic [31:0]   head_instr;
  logic [31:0]   head_rs1;
  logic          head_mem;

  function automatic logic is_mem_op(input logic [31:0] w);
    return (w[6:0] == 7'b0000111) || (w[6:0] == 7'b0100111);
  endfunction

  // Acceptance depends on occupancy only; a same-cycle pop does not open a slot.
  assign core_ready = (count != CW'(DEPTH)) && !rst;
  // A push coinciding with flush is dropped along with the queued entries.
  assign push       = core_valid && core_ready && !flush;
  // The output slot can take a new instruction unless a mem op still has hold cycles left.
  assign slot_free  = (state != MEM_HOLD) || (hold_cnt == 4'd0);
  assign pop        = slot_free && (count != '0) && !flush;
  assign head_instr = instr_mem[rd_ptr];
  assign head_rs1   = rs1_mem[rd_ptr];
  assign head_mem   = is_mem_op(head_instr);

  // FIFO storage: data only, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= core_instr;
      rs1_mem[wr_ptr]   <= core_rs1;
    end
  end

  // Pointers and occupancy; flush empties the queue by snapping rd_ptr to wr_ptr.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Issue FSM with registered outputs: pop into the output stage, hold mem ops, else NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= 4'd0;
      issue_instr  <= NOP_INSTR;
      issue_rs1    <= 32'd0;
      issue_valid  <= 1'b0;
      issue_is_mem <= 1'b0;
    end else if (pop) begin
      issue_instr  <= head_instr;
      issue_rs1    <= head_rs1;
      issue_valid  <= 1'b1;
      issue_is_mem <= head_mem;
      if (head_mem && HOLD_EN) begin
        state    <= MEM_HOLD;
        hold_cnt <= HOLD_INIT;
      end else begin
        state    <= EXEC;
        hold_cnt <= 4'd0;
      end
    end else if (slot_free) begin
      state        <= IDLE;
      hold_cnt     <= 4'd0;
      issue_instr  <= NOP_INSTR;
      issue_rs1    <= 32'd0;
      issue_valid  <= 1'b0;
      issue_is_mem <= 1'b0;
    end else begin
      hold_cnt <= hold_cnt - 4'd1;
    end
  end

`ifdef PSIMD_ISSUE_STATS_EN
  // Free-running statistics, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= 32'd0;
      stat_stall  <= 32'd0;
    end else begin
      if (pop)                       stat_issued <= stat_issued + 32'd1;
      if (core_valid && !core_ready) stat_stall  <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
